// File: rtl/udp_rx_tile_pkg.sv
// Shared UDP RX tile types: NoC flit/header layout and the output arbiter state encoding.
package udp_rx_tile_pkg;

  localparam int unsigned NOC_DATA_WIDTH = 64;
  localparam int unsigned MSG_LENGTH_W   = 8;

  // NoC header flit; msg_len counts the body flits that follow the header
  typedef struct packed {
    logic [13:0]             dest_chipid;
    logic [7:0]              dest_x;
    logic [7:0]              dest_y;
    logic [3:0]              fbits;
    logic [MSG_LENGTH_W-1:0] msg_len;
    logic [7:0]              msg_type;
    logic [7:0]              mshr_tag;
    logic [5:0]              options;
  } noc_hdr_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR_HOLD = 2'd1,
    BODY     = 2'd2
  } arb_state_e;

endpackage

// File: rtl/udp_rx_noc_out_arb_rr.sv
// Combinational round-robin picker: first requester at or above rr_ptr, wrapping modulo NUM_SRCS.
module udp_rx_noc_out_arb_rr #(
  parameter int unsigned NUM_SRCS = 2,
  parameter int unsigned SEL_W    = $clog2(NUM_SRCS)
) (
  input  logic [NUM_SRCS-1:0] i_req,
  input  logic [SEL_W-1:0]    i_rr_ptr,
  output logic [SEL_W-1:0]    o_grant,
  output logic                o_any_req
);

  int            w_sum;
  logic [SEL_W-1:0] w_idx;

  // Scan farthest-first so the requester nearest the pointer is the last writer
  always_comb begin
    o_grant   = i_rr_ptr;
    o_any_req = 1'b0;
    w_sum     = 0;
    w_idx     = '0;
    for (int i = int'(NUM_SRCS) - 1; i >= 0; i--) begin
      w_sum = int'(i_rr_ptr) + i;
      if (w_sum >= int'(NUM_SRCS)) begin
        w_sum = w_sum - int'(NUM_SRCS);
      end
      w_idx = SEL_W'(w_sum);
      if (i_req[w_idx]) begin
        o_grant   = w_idx;
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_rx_noc_out_arb.sv
// Packet-granular round-robin arbiter merging UDP RX out-copy engines onto one noc0 vrtoc port.
module udp_rx_noc_out_arb
  import udp_rx_tile_pkg::*;
#(
  parameter int unsigned NUM_SRCS = 2,
  parameter int unsigned SEL_W    = $clog2(NUM_SRCS)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_SRCS-1:0]                      src_noc0_vrtoc_val,
  input  logic [NUM_SRCS-1:0][NOC_DATA_WIDTH-1:0]  src_noc0_vrtoc_data,
  output logic [NUM_SRCS-1:0]                      noc0_vrtoc_src_rdy,
  output logic                                     arb_noc0_vrtoc_val,
  output logic [NOC_DATA_WIDTH-1:0]                arb_noc0_vrtoc_data,
  input  logic                                     noc0_vrtoc_arb_rdy,
  output logic                                     arb_busy
);

  arb_state_e              r_state;
  logic [SEL_W-1:0]        r_rr_ptr;
  logic [SEL_W-1:0]        r_lock_sel;
  logic [MSG_LENGTH_W-1:0] r_flit_cnt;

  logic [SEL_W-1:0]        w_rr_grant;
  logic                    w_rr_any;
  logic [SEL_W-1:0]        w_sel;
  logic                    w_val;
  logic                    w_hs;
  noc_hdr_t                w_flit;
  logic [MSG_LENGTH_W-1:0] w_len;

  function automatic logic [SEL_W-1:0] f_next(input logic [SEL_W-1:0] s);
    if (int'(s) >= int'(NUM_SRCS) - 1) begin
      return '0;
    end
    return s + SEL_W'(1);
  endfunction

  udp_rx_noc_out_arb_rr #(
    .NUM_SRCS (NUM_SRCS),
    .SEL_W    (SEL_W)
  ) u_rr (
    .i_req     (src_noc0_vrtoc_val),
    .i_rr_ptr  (r_rr_ptr),
    .o_grant   (w_rr_grant),
    .o_any_req (w_rr_any)
  );

  // Free grant only in IDLE; once a header is seen the locked source owns the port
  always_comb begin
    w_sel  = (r_state == IDLE) ? w_rr_grant : r_lock_sel;
    w_val  = (r_state == IDLE) ? w_rr_any : src_noc0_vrtoc_val[w_sel];
    w_flit = noc_hdr_t'(src_noc0_vrtoc_data[w_sel]);
    w_len  = w_flit.msg_len;
    w_hs   = w_val & noc0_vrtoc_arb_rdy;
  end

  // Zero-latency flit mux; val and rdy are forced low while reset is asserted
  always_comb begin
    arb_noc0_vrtoc_val  = w_val & rst;
    arb_noc0_vrtoc_data = w_flit;
    noc0_vrtoc_src_rdy  = '0;
    for (int i = 0; i < int'(NUM_SRCS); i++) begin
      noc0_vrtoc_src_rdy[i] = rst & noc0_vrtoc_arb_rdy & (w_sel == SEL_W'(i));
    end
  end

  assign arb_busy = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_lock_sel <= '0;
      r_flit_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_val) begin
            if (!noc0_vrtoc_arb_rdy) begin
              r_lock_sel <= w_sel;
              r_state    <= HDR_HOLD;
            end else if (w_len == '0) begin
              r_rr_ptr <= f_next(w_sel);
            end else begin
              r_lock_sel <= w_sel;
              r_flit_cnt <= w_len;
              r_state    <= BODY;
            end
          end
        end
        HDR_HOLD: begin
          if (w_hs) begin
            if (w_len == '0) begin
              r_rr_ptr <= f_next(r_lock_sel);
              r_state  <= IDLE;
            end else begin
              r_flit_cnt <= w_len;
              r_state    <= BODY;
            end
          end
        end
        BODY: begin
          // flit_cnt >= 1 here, so the decrement cannot wrap
          if (w_hs) begin
            r_flit_cnt <= r_flit_cnt - MSG_LENGTH_W'(1);
            if (r_flit_cnt == MSG_LENGTH_W'(1)) begin
              r_rr_ptr <= f_next(r_lock_sel);
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/udp_rx_noc_out_arb.md
# udp_rx_noc_out_arb

Packet-granular round-robin arbiter that lets several UDP RX NoC output engines share one noc0 vrtoc injection port. It sits between the per-flow UDP RX out-copy engines and the router interface. The datapath is a zero-latency combinational flit mux. The block's sequential state handles three things:
- locking the grant for a whole NoC message, counted from the header's length field;
- holding a header grant stable under backpressure;
- advancing the round-robin pointer after each message.

## Interface
Parameters:
- NUM_SRCS, 2, number of requesting engines (2..4)
- SEL_W, $clog2(NUM_SRCS), grant index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- src_noc0_vrtoc_val  in  NUM_SRCS  per-source flit valid
- src_noc0_vrtoc_data  in  NUM_SRCS x `NOC_DATA_WIDTH  per-source flit
- noc0_vrtoc_src_rdy  out  NUM_SRCS  per-source ready
- arb_noc0_vrtoc_val  out  1  merged flit valid
- arb_noc0_vrtoc_data  out  `NOC_DATA_WIDTH  merged flit
- noc0_vrtoc_arb_rdy  in  1  router ready
- arb_busy  out  1  high while in HDR_HOLD or BODY

## Operation
- The first flit of every message is a header. Its msg_len field gives the count of body flits that follow, and may be 0.
- The FSM has three states: IDLE, HDR_HOLD, BODY.

IDLE:
- The grant is combinational: the first source with val high, searching from rr_ptr upward modulo NUM_SRCS.
- The granted source's val, data and rdy connect through to the output. All other rdy are 0.
- If the header handshakes (val & rdy):
  - msg_len==0: stay in IDLE; rr_ptr <= grant+1 (mod NUM_SRCS).
  - otherwise: flit_cnt <= msg_len, lock_sel <= grant, go to BODY.
- If the header is valid but router rdy is low: lock_sel <= grant, go to HDR_HOLD.

HDR_HOLD:
- lock_sel is connected, so the output cannot switch source while a header is stalled.
- When the header handshakes, apply the same msg_len rule as IDLE.

BODY:
- lock_sel is connected.
- On each handshake flit_cnt decrements.
- On a handshake with flit_cnt==1: go to IDLE, rr_ptr <= lock_sel+1.
- A source deasserting val mid-message gives output val=0. The lock is held, with no timeout.

Arithmetic:
- flit_cnt is MSG_LENGTH_W wide (the width of the header's msg_len field).
- flit_cnt never underflows: a decrement happens only in BODY, where flit_cnt>=1.

## Timing
- Zero-cycle latency for data, val and rdy. There is no flit storage.
- Grant, lock and pointer updates take effect the cycle after the triggering edge.
- Back-to-back messages from different sources proceed with no bubble.
- After reset (rst low):
  - state = IDLE; rr_ptr = 0; lock_sel = 0; flit_cnt = 0.
  - arb_noc0_vrtoc_val = 0 and noc0_vrtoc_src_rdy = 0 while rst is asserted (both gated by reset).
  - arb_busy = 0.
- Reset mid-message drops the message with no recovery. Sources are reset on the same rst.
- When several sources are valid in the same cycle, the one nearest rr_ptr (going upward) wins. A source granted at pointer p gets lowest priority next time.
- Backpressure: all outputs are held unchanged while router rdy is low. The grant is guaranteed stable from the first valid header.

## Structure
- Shared package udp_rx_tile_pkg gains:
  - the arb_state_e enum (IDLE, HDR_HOLD, BODY).
- The header field decode uses the existing shared NoC header typedef (msg_len).
- One sub-module, udp_rx_noc_out_arb_rr: a combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: grant index and any_req.
  - Instantiated in IDLE grant logic.
- Control and mux live in the top module. There is no separate datap.

## Test plan
- Single source 0 sends a header with msg_len=3 plus 3 bodies, rdy always high → 4 output flits in 4 cycles; rr_ptr=1 after; arb_busy high for cycles 2–4.
- Sources 0 and 1 both start a msg_len=2 message in the same cycle, rr_ptr=0 → source 0's 3 flits, then source 1's 3 flits with no bubble and no interleaving; rr_ptr=0 at the end.
- Source 1 header valid with router rdy low for 5 cycles, while source 0 raises val in cycle 2 → output stays source 1's header; noc0_vrtoc_src_rdy[0]=0 throughout; source 1's message completes first.
- msg_len=0 headers from sources 0,1,0,1 back-to-back → 4 single-flit messages in 4 cycles; state never leaves IDLE; grants alternate.
- Source 0 drops val for 3 cycles mid-body (msg_len=4) while source 1 requests → output val=0 in those cycles; source 1 is not granted until source 0's last body flit.
- rst asserted in BODY with flit_cnt=2 → same cycle: output val=0, all rdy=0; after release: state IDLE, rr_ptr=0, and a fresh msg_len=1 message from source 1 passes correctly.
